// File: rtl/multi_user_free_queue_pkg.sv
// Shared constants and state encoding for the free-pointer queue.
// Default geometry: 512 cells addressed by 10-bit pointers.
package multi_user_free_queue_pkg;

    localparam int FQ_PTR_W = 10;
    localparam int FQ_DEPTH = 512;
    localparam int FQ_CNT_W = 10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fq_state_t;

endpackage

// File: rtl/multi_user_free_queue_ptr_ram.sv
// Pointer storage: one synchronous write port and one asynchronous read port.
// The asynchronous read gives the queue its show-ahead head output.
module fq_ptr_ram #(
    parameter int DEPTH = 512,
    parameter int PTR_W = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PTR_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PTR_W-1:0] rdata
);

    logic [PTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multi_user_free_queue.sv
// Free-pointer queue: self-fills with every cell index after reset, then
// hands pointers out (pop) and takes released pointers back (push) in FIFO order.
module multi_user_free_queue
    import multi_user_free_queue_pkg::*;
#(
    parameter int PTR_W = FQ_PTR_W,
    parameter int DEPTH = FQ_DEPTH,
    parameter int CNT_W = FQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ptr_din,
    input  logic             FQ_wr,
    input  logic             FQ_rd,
    output logic [PTR_W-1:0] ptr_dout_s,
    output logic             ptr_fifo_empty,
    output logic             FQ_act,
    output logic [CNT_W-1:0] FQ_count
);

    localparam int AW = $clog2(DEPTH);

    fq_state_t        state_q, state_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW-1:0]    init_idx_q, init_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             act_q, act_d;
    logic             empty_q, empty_d;

    logic             ram_we;
    logic [PTR_W-1:0] ram_wdata;
    logic [PTR_W-1:0] ram_rdata;
    logic             do_pop;
    logic             do_push;

    fq_ptr_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (tail_q),
        .wdata (ram_wdata),
        .raddr (head_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        init_idx_d = init_idx_q;
        count_d    = count_q;
        act_d      = act_q;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        do_pop     = 1'b0;
        do_push    = 1'b0;

        case (state_q)
            ST_INIT: begin
                ram_we     = 1'b1;
                ram_wdata  = PTR_W'(init_idx_q);
                tail_d     = tail_q + AW'(1);
                count_d    = count_q + CNT_W'(1);
                init_idx_d = init_idx_q + AW'(1);
                if (init_idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    act_d   = 1'b1;
                end
            end
            ST_RUN: begin
                do_pop  = FQ_rd && (count_q != '0);
                // When full, a push is only accepted alongside a pop that frees a slot.
                do_push = FQ_wr && ((count_q != CNT_W'(DEPTH)) || do_pop);
                if (do_pop) begin
                    head_d = head_q + AW'(1);
                end
                if (do_push) begin
                    ram_we    = 1'b1;
                    ram_wdata = ptr_din[PTR_W-1:0];
                    tail_d    = tail_q + AW'(1);
                end
                if (do_push && !do_pop) begin
                    count_d = count_q + CNT_W'(1);
                end else if (do_pop && !do_push) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            head_q     <= '0;
            tail_q     <= '0;
            init_idx_q <= '0;
            count_q    <= '0;
            act_q      <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            init_idx_q <= init_idx_d;
            count_q    <= count_d;
            act_q      <= act_d;
            empty_q    <= empty_d;
        end
    end

    // Forced to zero while empty so stale or unwritten RAM never leaks out.
    assign ptr_dout_s     = empty_q ? '0 : ram_rdata;
    assign ptr_fifo_empty = empty_q;
    assign FQ_act         = act_q;
    assign FQ_count       = count_q;

    generate
        if (PTR_W < 16) begin : g_din_hi
            logic unused_din_hi;
            assign unused_din_hi = ^ptr_din[15:PTR_W];
        end
    endgenerate

endmodule

// File: tb/tb_multi_user_free_queue.sv
// Directed bench for the free-pointer queue: init fill, pops, pushes,
// concurrent operations at empty/full/mid occupancy, and mid-traffic reset.
module tb_multi_user_free_queue;

    logic        clk;
    logic        rst;
    logic [15:0] ptr_din;
    logic        FQ_wr;
    logic        FQ_rd;
    logic [9:0]  ptr_dout_s;
    logic        ptr_fifo_empty;
    logic        FQ_act;
    logic [9:0]  FQ_count;

    int n_checks = 0;
    int n_fail   = 0;
    int q[$];

    multi_user_free_queue dut (
        .clk            (clk),
        .rst            (rst),
        .ptr_din        (ptr_din),
        .FQ_wr          (FQ_wr),
        .FQ_rd          (FQ_rd),
        .ptr_dout_s     (ptr_dout_s),
        .ptr_fifo_empty (ptr_fifo_empty),
        .FQ_act         (FQ_act),
        .FQ_count       (FQ_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_act;
        rst = 1'b1; FQ_rd = 1'b0; FQ_wr = 1'b0; ptr_din = '0;
        step(); step();
        n_checks++;
        if (FQ_act !== 1'b0 || FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1 || ptr_dout_s !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: act=%b count=%0d empty=%b dout=%0d, want act=0 count=0 empty=1 dout=0",
                     FQ_act, FQ_count, ptr_fifo_empty, ptr_dout_s);
        end
        rst = 1'b0;
        for (int c = 1; c <= 512; c++) begin
            step();
            exp_act = (c == 512);
            n_checks++;
            if (FQ_act !== exp_act) begin
                n_fail++;
                $display("FAIL init_act cycle %0d: act=%b want %b", c, FQ_act, exp_act);
            end
        end
        n_checks++;
        if (FQ_count !== 10'd512 || ptr_fifo_empty !== 1'b0 || ptr_dout_s !== 10'd0) begin
            n_fail++;
            $display("FAIL init_done: count=%0d empty=%b dout=%0d, want count=512 empty=0 dout=0",
                     FQ_count, ptr_fifo_empty, ptr_dout_s);
        end
        q.delete();
        for (int i = 0; i < 512; i++) q.push_back(i);
        $display("test_reset: init complete, count=%0d", FQ_count);
    endtask

    task automatic test_pop3();
        for (int i = 0; i < 3; i++) begin
            FQ_rd = 1'b1;
            n_checks++;
            if (ptr_dout_s !== 10'(i)) begin
                n_fail++;
                $display("FAIL pop3_ptr %0d: dout=%0d want %0d", i, ptr_dout_s, i);
            end
            void'(q.pop_front());
            step();
        end
        FQ_rd = 1'b0;
        n_checks++;
        if (ptr_dout_s !== 10'd3 || FQ_count !== 10'd509) begin
            n_fail++;
            $display("FAIL pop3_after: dout=%0d count=%0d, want dout=3 count=509", ptr_dout_s, FQ_count);
        end
        $display("test_pop3: head=%0d count=%0d", ptr_dout_s, FQ_count);
    endtask

    task automatic test_drain_and_push();
        int exp;
        int errs = 0;
        while (q.size() > 0) begin
            FQ_rd = 1'b1;
            exp = q.pop_front();
            if (ptr_dout_s !== 10'(exp)) errs++;
            step();
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL drain_order: %0d out-of-order pointers, want 0", errs);
        end
        FQ_rd = 1'b0;
        n_checks++;
        if (FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: count=%0d empty=%b, want count=0 empty=1", FQ_count, ptr_fifo_empty);
        end
        FQ_rd = 1'b1;
        step();
        FQ_rd = 1'b0;
        n_checks++;
        if (FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: count=%0d empty=%b, want count=0 empty=1", FQ_count, ptr_fifo_empty);
        end
        FQ_wr = 1'b1; ptr_din = 16'hFC05;
        step();
        FQ_wr = 1'b0;
        q.push_back(5);
        n_checks++;
        if (ptr_dout_s !== 10'h005 || FQ_count !== 10'd1 || ptr_fifo_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL push_empty: dout=%0h count=%0d empty=%b, want dout=005 count=1 empty=0",
                     ptr_dout_s, FQ_count, ptr_fifo_empty);
        end
        $display("test_drain_and_push: head=%0h count=%0d", ptr_dout_s, FQ_count);
    endtask

    task automatic test_simul_empty_full();
        FQ_rd = 1'b1;
        step();
        FQ_rd = 1'b0;
        void'(q.pop_front());
        FQ_rd = 1'b1; FQ_wr = 1'b1; ptr_din = 16'd7;
        step();
        FQ_rd = 1'b0; FQ_wr = 1'b0;
        q.push_back(7);
        n_checks++;
        if (FQ_count !== 10'd1 || ptr_dout_s !== 10'd7) begin
            n_fail++;
            $display("FAIL rdwr_at_empty: count=%0d dout=%0d, want count=1 dout=7", FQ_count, ptr_dout_s);
        end
        for (int j = 1; j < 512; j++) begin
            FQ_wr = 1'b1; ptr_din = 16'(j);
            step();
            q.push_back(j);
        end
        FQ_wr = 1'b1; ptr_din = 16'd55;
        step();
        FQ_wr = 1'b0;
        n_checks++;
        if (FQ_count !== 10'd512 || ptr_dout_s !== 10'd7) begin
            n_fail++;
            $display("FAIL overflow: count=%0d dout=%0d, want count=512 dout=7", FQ_count, ptr_dout_s);
        end
        FQ_rd = 1'b1; FQ_wr = 1'b1; ptr_din = 16'd999;
        step();
        FQ_rd = 1'b0; FQ_wr = 1'b0;
        void'(q.pop_front());
        q.push_back(999);
        n_checks++;
        if (FQ_count !== 10'd512 || ptr_dout_s !== 10'd1) begin
            n_fail++;
            $display("FAIL rdwr_at_full: count=%0d dout=%0d, want count=512 dout=1", FQ_count, ptr_dout_s);
        end
        $display("test_simul_empty_full: head=%0d count=%0d", ptr_dout_s, FQ_count);
    endtask

    task automatic test_concurrent_ten();
        int exp;
        int errs = 0;
        while (q.size() > 10) begin
            FQ_rd = 1'b1;
            exp = q.pop_front();
            if (ptr_dout_s !== 10'(exp)) errs++;
            step();
        end
        FQ_rd = 1'b0;
        n_checks++;
        if (errs != 0 || FQ_count !== 10'd10) begin
            n_fail++;
            $display("FAIL pop_to_ten: errs=%0d count=%0d, want errs=0 count=10", errs, FQ_count);
        end
        for (int k = 0; k < 5; k++) begin
            FQ_rd = 1'b1; FQ_wr = 1'b1; ptr_din = 16'd300;
            exp = q.pop_front();
            q.push_back(300);
            n_checks++;
            if (ptr_dout_s !== 10'(exp)) begin
                n_fail++;
                $display("FAIL rdwr_ten_ptr %0d: dout=%0d want %0d", k, ptr_dout_s, exp);
            end
            step();
            n_checks++;
            if (FQ_count !== 10'd10) begin
                n_fail++;
                $display("FAIL rdwr_ten_count %0d: count=%0d want 10", k, FQ_count);
            end
        end
        FQ_rd = 1'b0; FQ_wr = 1'b0;
        while (q.size() > 0) begin
            FQ_rd = 1'b1;
            exp = q.pop_front();
            n_checks++;
            if (ptr_dout_s !== 10'(exp)) begin
                n_fail++;
                $display("FAIL ten_order: dout=%0d want %0d", ptr_dout_s, exp);
            end
            step();
        end
        FQ_rd = 1'b0;
        n_checks++;
        if (FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ten_drained: count=%0d empty=%b, want count=0 empty=1", FQ_count, ptr_fifo_empty);
        end
        $display("test_concurrent_ten: count=%0d", FQ_count);
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 200; j++) begin
            FQ_wr = 1'b1; ptr_din = 16'(j + 100);
            step();
        end
        n_checks++;
        if (FQ_count !== 10'd200) begin
            n_fail++;
            $display("FAIL mid_fill: count=%0d want 200", FQ_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; FQ_wr = 1'b0;
        n_checks++;
        if (FQ_act !== 1'b0 || FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1 || ptr_dout_s !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: act=%b count=%0d empty=%b dout=%0d, want act=0 count=0 empty=1 dout=0",
                     FQ_act, FQ_count, ptr_fifo_empty, ptr_dout_s);
        end
        for (int c = 1; c < 512; c++) step();
        n_checks++;
        if (FQ_act !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_early: act=%b at cycle 511, want 0", FQ_act);
        end
        step();
        n_checks++;
        if (FQ_act !== 1'b1 || FQ_count !== 10'd512 || ptr_dout_s !== 10'd0) begin
            n_fail++;
            $display("FAIL reinit_done: act=%b count=%0d dout=%0d, want act=1 count=512 dout=0",
                     FQ_act, FQ_count, ptr_dout_s);
        end
        $display("test_reset_mid: act=%b count=%0d", FQ_act, FQ_count);
    endtask

    initial begin
        rst = 1'b1; FQ_rd = 1'b0; FQ_wr = 1'b0; ptr_din = '0;
        test_reset();
        test_pop3();
        test_drain_and_push();
        test_simul_empty_full();
        test_concurrent_ten();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
